// File: rtl/pwm_profile_sequencer_if.sv
// AXI4-Lite bus bundle used by pwm_profile_sequencer to reach the timer register block.
interface pwm_profile_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwm_profile_sequencer.sv
// Walks a table of PWM profiles, programming the timer over AXI4-Lite and dwelling on WRAP events.
// Optional macro PWM_SEQ_LOOP_EN adds cfg_loop to repeat the table until stop or error.
module pwm_profile_sequencer #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  tbl_we,
  input  logic [DEPTH_LOG2-1:0] tbl_addr,
  input  logic [31:0]           tbl_period,
  input  logic [31:0]           tbl_duty,
  input  logic [7:0]            tbl_reps,
  input  logic [DEPTH_LOG2:0]   num_entries,
`ifdef PWM_SEQ_LOOP_EN
  input  logic                  cfg_loop,
`endif
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DEPTH_LOG2-1:0] cur_idx,
  pwm_profile_sequencer_if.master m_axi
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StPeriod  = 4'd1;
  localparam logic [3:0] StDuty    = 4'd2;
  localparam logic [3:0] StEnable  = 4'd3;
  localparam logic [3:0] StGap     = 4'd4;
  localparam logic [3:0] StPoll    = 4'd5;
  localparam logic [3:0] StClear   = 4'd6;
  localparam logic [3:0] StAdvance = 4'd7;
  localparam logic [3:0] StDisable = 4'd8;

  localparam int unsigned Entries = 2 ** DEPTH_LOG2;
  localparam logic [7:0]  GapInit = 8'(POLL_GAP);

  logic [31:0] period_mem [Entries];
  logic [31:0] duty_mem   [Entries];
  logic [7:0]  reps_mem   [Entries];

  logic [3:0]            state_q;
  logic [DEPTH_LOG2-1:0] cur_idx_q;
  logic [DEPTH_LOG2:0]   num_q;
  logic [7:0]            rep_cnt_q;
  logic [7:0]            gap_cnt_q;
  logic                  act_q;
  logic                  en_done_q;
  logic                  loop_q;
  logic                  err_q;
  logic                  done_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;

  logic                  is_wr;
  logic                  wr_cmp;
  logic                  rd_cmp;
  logic                  cmp_err;
  logic                  aw_ok;
  logic                  w_ok;
  logic [3:0]            ok_next;
  logic [3:0]            cmp_next;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [DEPTH_LOG2:0]   idx_next;
  logic                  unused_rdata;

  // Table only changes while idle, so addresses/data read from it are stable during a transaction.
  always_ff @(posedge ACLK) begin
    if (tbl_we && state_q == StIdle) begin
      period_mem[tbl_addr] <= tbl_period;
      duty_mem[tbl_addr]   <= tbl_duty;
      reps_mem[tbl_addr]   <= tbl_reps;
    end
  end

  always_comb begin
    is_wr    = (state_q == StPeriod) || (state_q == StDuty) || (state_q == StEnable) ||
               (state_q == StClear) || (state_q == StDisable);
    wr_cmp   = is_wr && bready_q && m_axi.bvalid;
    rd_cmp   = (state_q == StPoll) && rready_q && m_axi.rvalid;
    cmp_err  = (wr_cmp && m_axi.bresp != 2'b00) || (rd_cmp && m_axi.rresp != 2'b00);
    aw_ok    = !awvalid_q || m_axi.awready;
    w_ok     = !wvalid_q || m_axi.wready;
    idx_next = {1'b0, cur_idx_q} + (DEPTH_LOG2 + 1)'(1);

    ok_next = StIdle;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      StPeriod: begin
        ok_next = StDuty;
        wr_addr = ADDR_WIDTH'(8'h04);
        wr_data = period_mem[cur_idx_q];
      end
      StDuty: begin
        ok_next = en_done_q ? StGap : StEnable;
        wr_addr = ADDR_WIDTH'(8'h08);
        wr_data = duty_mem[cur_idx_q];
      end
      StEnable: begin
        ok_next = StGap;
        wr_addr = ADDR_WIDTH'(8'h00);
        wr_data = 32'h1;
      end
      StPoll:  ok_next = m_axi.rdata[0] ? StClear : StGap;
      StClear: begin
        ok_next = (rep_cnt_q <= 8'd1) ? StAdvance : StGap;
        wr_addr = ADDR_WIDTH'(8'h0C);
        wr_data = 32'h1;
      end
      StDisable: begin
        ok_next = StIdle;
        wr_addr = ADDR_WIDTH'(8'h00);
        wr_data = 32'h0;
      end
      default: ok_next = StIdle;
    endcase

    // The shutdown write always ends in IDLE, even if it errors or stop is still high.
    if (state_q == StDisable) begin
      cmp_next = StIdle;
    end else if (cmp_err || stop) begin
      cmp_next = StDisable;
    end else begin
      cmp_next = ok_next;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      cur_idx_q <= '0;
      num_q     <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      act_q     <= 1'b0;
      en_done_q <= 1'b0;
      loop_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && num_entries != '0) begin
            state_q   <= StPeriod;
            cur_idx_q <= '0;
            err_q     <= 1'b0;
            num_q     <= num_entries;
            en_done_q <= 1'b0;
`ifdef PWM_SEQ_LOOP_EN
            loop_q    <= cfg_loop;
`else
            loop_q    <= 1'b0;
`endif
          end
        end
        StGap: begin
          if (stop) begin
            state_q <= StDisable;
          end else if (gap_cnt_q == 8'd0) begin
            state_q <= StPoll;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        StAdvance: begin
          if (idx_next < num_q) begin
            cur_idx_q <= cur_idx_q + DEPTH_LOG2'(1);
            state_q   <= StPeriod;
          end else if (loop_q) begin
            cur_idx_q <= '0;
            state_q   <= StPeriod;
          end else begin
            state_q <= StDisable;
          end
        end
        default: begin
          if (!act_q) begin
            act_q <= 1'b1;
            if (state_q == StPoll) begin
              arvalid_q <= 1'b1;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end else if (wr_cmp || rd_cmp) begin
            act_q    <= 1'b0;
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            state_q  <= cmp_next;
            err_q    <= err_q | cmp_err;
            if (cmp_next == StGap)    gap_cnt_q <= GapInit;
            if (cmp_next == StIdle)   done_q    <= 1'b1;
            if (state_q == StEnable)  en_done_q <= 1'b1;
            if (state_q == StClear)   rep_cnt_q <= rep_cnt_q - 8'd1;
            if (state_q == StDuty) begin
              rep_cnt_q <= (reps_mem[cur_idx_q] == 8'd0) ? 8'd1 : reps_mem[cur_idx_q];
            end
          end else begin
            if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
            if (is_wr && !bready_q && aw_ok && w_ok) bready_q <= 1'b1;
            if (arvalid_q && m_axi.arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign m_axi.awaddr  = wr_addr;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = DATA_WIDTH'(wr_data);
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = ADDR_WIDTH'(8'h0C);
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;
  assign cur_idx = cur_idx_q;

  // Only the WRAP bit of STATUS matters here.
  assign unused_rdata = ^m_axi.rdata[DATA_WIDTH-1:1];

endmodule
